// File: rtl/tri_driver.sv
// tri_driver: initiator for the TRIANGLE side-length protocol.
// Takes one request (three side lengths) over valid/ready, serialises it onto
// in_valid/in_length, collects the three out_cos beats plus out_tri and hands
// them back as a single parallel response with an error flag.
// Optional feature: define TRI_TIMEOUT_EN to bound the wait for the first
// result beat to TIMEOUT cycles.
module tri_driver #(
    parameter int unsigned GAP     = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [7:0]  req_c,
    output logic        in_valid,
    output logic [7:0]  in_length,
    input  logic        out_valid,
    input  logic [15:0] out_cos,
    input  logic [1:0]  out_tri,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_cos0,
    output logic [15:0] rsp_cos1,
    output logic [15:0] rsp_cos2,
    output logic [1:0]  rsp_tri,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StSend0,
        StSend1,
        StSend2,
        StWait,
        StRecv1,
        StRecv2,
        StResp
    } state_t;

    // Gap counter only needs to count up to GAP-1; one spare bit keeps GAP=0/1 legal.
    localparam int unsigned GW = $clog2(GAP + 1) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

`ifdef TRI_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    state_t        state;
    logic [GW-1:0] gap_cnt;
    // Set once a response has been consumed; right after reset the gap is skipped.
    logic          gap_arm;
    logic [7:0]    len_b;
    logic [7:0]    len_c;

    // Single-process FSM: state, counters and every output are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            gap_cnt   <= '0;
            gap_arm   <= 1'b0;
            len_b     <= '0;
            len_c     <= '0;
            req_ready <= 1'b0;
            in_valid  <= 1'b0;
            in_length <= '0;
            rsp_valid <= 1'b0;
            rsp_cos0  <= '0;
            rsp_cos1  <= '0;
            rsp_cos2  <= '0;
            rsp_tri   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef TRI_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_ready) begin
                        if (req_valid) begin
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            in_valid  <= 1'b1;
                            in_length <= req_a;
                            len_b     <= req_b;
                            len_c     <= req_c;
                            // Clear captures so an aborted reply never shows stale data.
                            rsp_cos0  <= '0;
                            rsp_cos1  <= '0;
                            rsp_cos2  <= '0;
                            rsp_tri   <= '0;
                            rsp_err   <= 1'b0;
                            state     <= StSend0;
                        end
                    end else if (!gap_arm || gap_cnt == GAP_LAST) begin
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                StSend0: begin
                    in_length <= len_b;
                    state     <= StSend1;
                end
                StSend1: begin
                    in_length <= len_c;
                    state     <= StSend2;
                end
                StSend2: begin
                    in_valid  <= 1'b0;
                    in_length <= '0;
`ifdef TRI_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                    state     <= StWait;
                end
                StWait: begin
                    // A beat arriving on the final allowed cycle wins over the timeout.
                    if (out_valid) begin
                        rsp_cos0 <= out_cos;
                        rsp_tri  <= out_tri;
                        state    <= StRecv1;
                    end
`ifdef TRI_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                StRecv1: begin
                    if (out_valid) begin
                        rsp_cos1 <= out_cos;
                        state    <= StRecv2;
                    end else begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end
                end
                StRecv2: begin
                    if (out_valid) begin
                        rsp_cos2 <= out_cos;
                    end else begin
                        rsp_err <= 1'b1;
                    end
                    rsp_valid <= 1'b1;
                    state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        gap_cnt   <= '0;
                        gap_arm   <= 1'b1;
                        req_ready <= (GAP == 0);
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_driver.sv
// Testbench for tri_driver: directed scenarios plus randomized transactions
// checked against a transaction-level model of the request/response rules.
// Build with TRI_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT=8).
module tb_tri_driver;

    localparam int unsigned GAP     = 1;
    localparam int unsigned TIMEOUT = 8;
`ifdef TRI_TIMEOUT_EN
    localparam int MAXD    = 7;
    localparam int BASIC_D = 7;
`else
    localparam int MAXD    = 20;
    localparam int BASIC_D = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a, req_b, req_c;
    logic        in_valid;
    logic [7:0]  in_length;
    logic        out_valid;
    logic [15:0] out_cos;
    logic [1:0]  out_tri;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_cos0, rsp_cos1, rsp_cos2;
    logic [1:0]  rsp_tri;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    tri_driver #(
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .in_valid  (in_valid),
        .in_length (in_length),
        .out_valid (out_valid),
        .out_cos   (out_cos),
        .out_tri   (out_tri),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_cos0  (rsp_cos0),
        .rsp_cos1  (rsp_cos1),
        .rsp_cos2  (rsp_cos2),
        .rsp_tri   (rsp_tri),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    // Issue a request and check the three length beats; returns on the first WAIT cycle.
    task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input bit spur);
        wait_ready();
        if (spur) begin
            out_valid = 1'b1;
            out_cos   = 16'($urandom);
            @(negedge clk);
            out_valid = 1'b0;
            check("idle_spur_ready", {31'b0, req_ready}, 32'd1);
        end
        check("idle_busy", {31'b0, busy}, 32'd0);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_c = c;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        req_c = 8'($urandom);
        check("send0_valid", {31'b0, in_valid}, 32'd1);
        check("send0_len", {24'b0, in_length}, {24'b0, a});
        check("send0_ready", {31'b0, req_ready}, 32'd0);
        check("send0_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("send1_len", {24'b0, in_length}, {24'b0, b});
        if (spur) begin
            out_valid = 1'b1;
            out_cos   = 16'($urandom);
        end
        @(negedge clk);
        out_valid = 1'b0;
        check("send2_len", {24'b0, in_length}, {24'b0, c});
        @(negedge clk);
        check("wait_in_valid", {31'b0, in_valid}, 32'd0);
        check("wait_in_len", {24'b0, in_length}, 32'd0);
    endtask

    // Drive the reply, then check the response against the protocol rules,
    // hold it under backpressure, consume it and check the idle gap.
    task automatic reply_and_check(input int d, input int nbeats, input logic [15:0] c0,
                                   input logic [15:0] c1, input logic [15:0] c2,
                                   input logic [1:0] tri_v, input int hold);
        logic [15:0] vals[3];
        logic [15:0] exp_cos[3];
        logic [1:0]  exp_tri;
        logic        exp_err;
        int          n;
        vals[0] = c0;
        vals[1] = c1;
        vals[2] = c2;
        for (int i = 0; i < 3; i++) exp_cos[i] = (i < nbeats) ? vals[i] : 16'h0;
        exp_tri = (nbeats > 0) ? tri_v : 2'd0;
        exp_err = (nbeats < 3);
        rsp_ready = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < nbeats; i++) begin
            out_valid = 1'b1;
            out_cos   = (i < 3) ? vals[i] : 16'($urandom);
            out_tri   = (i == 0) ? tri_v : 2'($urandom);
            @(negedge clk);
            if (i == 2) check("rsp_latency", {31'b0, rsp_valid}, 32'd1);
        end
        out_valid = 1'b0;
        out_cos   = 16'($urandom);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("rsp_cos0", {16'b0, rsp_cos0}, {16'b0, exp_cos[0]});
            check("rsp_cos1", {16'b0, rsp_cos1}, {16'b0, exp_cos[1]});
            check("rsp_cos2", {16'b0, rsp_cos2}, {16'b0, exp_cos[2]});
            check("rsp_tri", {30'b0, rsp_tri}, {30'b0, exp_tri});
            check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("post_busy", {31'b0, busy}, 32'd0);
        for (int g = 0; g < int'(GAP); g++) begin
            check("gap_ready_low", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check("gap_ready_high", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int nb;
        int sel;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        out_valid = 1'b0;
        out_cos   = '0;
        out_tri   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_in_valid", {31'b0, in_valid}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_fields", {rsp_cos0, rsp_cos1}, 32'd0);
        check("rst_misc", {5'b0, rsp_cos2, rsp_tri, rsp_err, in_length}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {31'b0, req_ready}, 32'd1);

        // Basic transfer with a 20-cycle backpressure hold.
        send_req(8'd3, 8'd4, 8'd5, 1'b0);
        reply_and_check(BASIC_D, 3, 16'h0CCD, 16'h0999, 16'h0000, 2'd1, 20);

        // Broken reply: two beats then silence.
        send_req(8'd7, 8'd8, 8'd9, 1'b0);
        reply_and_check(2, 2, 16'h1111, 16'h2222, 16'h3333, 2'd2, 1);

        // Spurious beats in IDLE and SEND1, then a normal reply.
        send_req(8'd10, 8'd11, 8'd12, 1'b1);
        reply_and_check(1, 3, 16'hABCD, 16'h1234, 16'h5678, 2'd3, 0);

        // Fourth beat lands in RESP and is ignored.
        send_req(8'd1, 8'd2, 8'd3, 1'b0);
        reply_and_check(0, 4, 16'hFFFF, 16'h8000, 16'h0001, 2'd0, 3);

        // Mid-transfer reset during SEND1.
        wait_ready();
        req_valid = 1'b1;
        req_a = 8'd20;
        req_b = 8'd21;
        req_c = 8'd22;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_send1_len", {24'b0, in_length}, 32'd21);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_valid", {31'b0, in_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);

`ifdef TRI_TIMEOUT_EN
        // No reply: response after exactly TIMEOUT WAIT cycles.
        send_req(8'd30, 8'd31, 8'd32, 1'b0);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            check("to_not_yet", {31'b0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        reply_and_check(0, 0, 16'h0, 16'h0, 16'h0, 2'd0, 1);
        // Reply on the last allowed WAIT cycle is captured.
        send_req(8'd33, 8'd34, 8'd35, 1'b0);
        reply_and_check(int'(TIMEOUT) - 1, 3, 16'h4444, 16'h5555, 16'h6666, 2'd2, 0);
`endif

        // Randomized transactions.
        for (int t = 0; t < 16; t++) begin
            sel = $urandom_range(0, 5);
            nb = (sel <= 2) ? 3 : (sel == 3) ? 4 : (sel == 4) ? 2 : 1;
            rsp_ready = 1'($urandom);
            send_req(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            reply_and_check($urandom_range(0, MAXD), nb, 16'($urandom), 16'($urandom),
                            16'($urandom), 2'($urandom), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_driver.md
Name: tri_driver

Overview:
- Synthesizable initiator for the TRIANGLE side-length protocol; the sending end that a hardware test harness or host adapter uses in place of a stimulus pattern.
- Accepts one triangle request (three 8-bit side lengths) over a valid/ready handshake and serializes it onto in_valid/in_length.
- Collects the three out_cos beats and the out_tri classification from the TRIANGLE core, then returns them as one parallel response with an error flag.

Parameters:
- GAP, 1, idle cycles forced in IDLE after a response is consumed before req_ready reasserts (0 = back-to-back).
- TIMEOUT, 1024, max cycles in WAIT for the first out_valid beat; only used when TRI_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  block can accept a request
- req_a  in  8  side length a, sent first
- req_b  in  8  side length b, sent second
- req_c  in  8  side length c, sent third
- in_valid  out  1  to TRIANGLE: length beat valid
- in_length  out  8  to TRIANGLE: current side length
- out_valid  in  1  from TRIANGLE: result beat valid
- out_cos  in  16  from TRIANGLE: cosine value of the current beat
- out_tri  in  2  from TRIANGLE: triangle class, sampled on the first result beat
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_cos0  out  16  first cos beat
- rsp_cos1  out  16  second cos beat
- rsp_cos2  out  16  third cos beat
- rsp_tri  out  2  class from the first beat
- rsp_err  out  1  1 = protocol error or timeout; cos/tri fields are partial
- busy  out  1  high in every state except IDLE

Behaviour:
- Protocol:
  - The request is three consecutive in_valid cycles carrying a, b, c.
  - The reply is three consecutive out_valid cycles carrying cos0, cos1, cos2, with out_tri valid on the first beat.
  - The reply arrives an arbitrary number of cycles after the last length beat.
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE and the gap counter clears.
  - All outputs go to 0: req_ready, in_valid, in_length, rsp_valid, rsp_* fields, rsp_err, busy.
  - req_ready rises on the first cycle after rst deasserts, ignoring GAP.
  - Reset mid-transfer abandons the transfer silently. The core-side reset is the integrator's responsibility.
- All outputs are registered. States and transitions:
  - IDLE: req_ready=1 once the gap counter reaches GAP. On req_valid&&req_ready at edge k, latch a, b, c and go to SEND0.
  - SEND0/SEND1/SEND2: in_valid=1 with in_length=a, b, c in cycles k+1, k+2, k+3. Then go to WAIT. in_valid=0 and in_length=0 outside SEND states.
  - WAIT: on out_valid=1, capture out_cos into cos0 and out_tri into tri, then go to RECV1.
  - RECV1: if out_valid=1, capture cos1 and go to RECV2. Else set err and go to RESP.
  - RECV2: if out_valid=1, capture cos2 and go to RESP with err=0. Else set err and go to RESP.
  - RESP: rsp_valid=1 and rsp_* held stable until rsp_ready=1. Then clear rsp_valid, reset the gap counter, and go to IDLE.
- Timing: minimum latency from the first out_valid beat to rsp_valid is 3 cycles (edge of beat 3, then registered).
- out_valid outside WAIT/RECV1/RECV2 (during IDLE, SEND*, RESP) is ignored and changes no state.
- A 4th consecutive out_valid beat lands in RESP or IDLE and is ignored.
- rsp_ready=1 when rsp_valid=0 has no effect.
- req_valid while busy is not accepted, since req_ready=0.
- Error case: capture registers not written in an aborted transfer are cleared to 0, never left stale.

Optional Feature:
- Macro: TRI_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry.
  - If it reaches TIMEOUT with no out_valid, go to RESP with rsp_err=1 and all cos/tri fields 0.
  - out_valid in the same cycle the count reaches TIMEOUT wins: capture it, no timeout.
- Undefined: no counter; WAIT waits indefinitely and the TIMEOUT parameter is unused.

Test Plan:
- Basic transfer: reset, req (3,4,5). Responder replies 10 cycles later with cos 16'h0CCD, 16'h0999, 16'h0000 and tri=2'd1 -> in_length 3,4,5 on cycles k+1..k+3; rsp_cos0..2 = 0CCD/0999/0000, rsp_tri=1, rsp_err=0.
- Backpressure and gap: hold rsp_ready=0 for 20 cycles -> rsp fields stable throughout. With GAP=1, req_ready=0 for exactly 1 cycle after acceptance, then 1.
- Broken reply: responder gives two out_valid beats (cos 16'h1111, 16'h2222) then drops -> rsp_err=1, cos0=1111, cos1=2222, cos2=0.
- Spurious beats: out_valid pulsed during SEND1 and during IDLE -> ignored; the following normal reply is captured correctly.
- Mid-transfer reset: assert rst during SEND1 -> next cycle in_valid=0, busy=0, rsp_valid=0. req_ready=1 the cycle after rst deasserts.
- Timeout (TRI_TIMEOUT_EN, TIMEOUT=8): no reply -> rsp_valid with rsp_err=1 after 8 WAIT cycles. Reply arriving exactly on the 8th WAIT cycle -> captured normally, err=0.
